// File: rtl/tri_pkg.sv
// Shared definitions for the triangle-rasterizer host: FSM state encoding,
// grid geometry and the pixel-index helper.
// Ports: none (package).
package tri_pkg;

    localparam int GRID    = 8;
    localparam int COORD_W = 3;
    localparam int PIX_W   = 2 * COORD_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND0   = 3'd1,
        ST_SEND1   = 3'd2,
        ST_SEND2   = 3'd3,
        ST_WAITB   = 3'd4,
        ST_COLLECT = 3'd5,
        ST_DONE    = 3'd6
    } tri_host_state_t;

    // Row-major pixel index: y*GRID + x, which for an 8x8 grid is {y, x}.
    function automatic logic [PIX_W-1:0] pix_idx(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tri_bitmap.sv
// Coverage bitmap with distinct-pixel counter; single-cycle test-and-set.
// Ports: clk/reset; clear (zero map and count), we + idx (mark one pixel);
//        bitmap (64-bit coverage), pix_cnt (0..64 distinct pixels).
module tri_bitmap
    import tri_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 we,
    input  logic [PIX_W-1:0]     idx,
    output logic [GRID*GRID-1:0] bitmap,
    output logic [PIX_W:0]       pix_cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitmap  <= '0;
            pix_cnt <= '0;
        end else if (clear) begin
            bitmap  <= '0;
            pix_cnt <= '0;
        end else if (we) begin
            bitmap[idx] <= 1'b1;
            // Only a previously clear bit counts, so repeated points are free.
            // At most 64 distinct bits exist, so the 7-bit count cannot wrap.
            if (!bitmap[idx]) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_host.sv
// Host for the 8x8 triangle rasterizer: sends three vertices, collects the
// returned point stream into a coverage bitmap and pulses done per job.
// Ports: clk/reset; start + v0..v2 (job request); nt/xi/yi (vertex stream
//        out); busy/po/xo/yo (point stream in); ready, done, bitmap, pix_cnt,
//        err (status).
// Optional watchdog: define TRI_HOST_TIMEOUT_EN to bound WAITB (BUSY_WAIT
// cycles) and COLLECT (COLLECT_MAX cycles); otherwise err is tied low.
module tri_host
    import tri_pkg::*;
#(
    parameter int GRID        = 8,
    parameter int BUSY_WAIT   = 4,
    parameter int COLLECT_MAX = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] v0x,
    input  logic [COORD_W-1:0] v0y,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v2y,
    output logic               nt,
    output logic [COORD_W-1:0] xi,
    output logic [COORD_W-1:0] yi,
    input  logic               busy,
    input  logic               po,
    input  logic [COORD_W-1:0] xo,
    input  logic [COORD_W-1:0] yo,
    output logic               ready,
    output logic               done,
    output logic [63:0]        bitmap,
    output logic [6:0]         pix_cnt,
    output logic               err
);

    // The datapath is sized by the package; reject a mismatched override.
    if (GRID != tri_pkg::GRID || BUSY_WAIT < 1 || COLLECT_MAX < 1) begin : g_bad_cfg
        $error("tri_host: unsupported parameter combination");
    end

    tri_host_state_t    state;
    logic [COORD_W-1:0] v1x_q, v1y_q, v2x_q, v2y_q;
    logic               accept;
    logic               wd_hit;

    assign ready  = (state == ST_IDLE);
    assign accept = (state == ST_IDLE) && start;

`ifdef TRI_HOST_TIMEOUT_EN
    localparam int WD_MAX = (BUSY_WAIT > COLLECT_MAX) ? BUSY_WAIT : COLLECT_MAX;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;
    logic            err_q;

    // The counter only advances while still waiting; any progress (busy rising
    // in WAITB) or leaving the state restarts it from zero.
    assign wd_run = ((state == ST_WAITB) && !busy) || ((state == ST_COLLECT) && busy);
    assign wd_hit = ((state == ST_WAITB)   && !busy && (wd_cnt == WD_W'(BUSY_WAIT - 1))) ||
                    ((state == ST_COLLECT) &&  busy && (wd_cnt == WD_W'(COLLECT_MAX - 1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= wd_run ? wd_cnt + 1'b1 : '0;
            if (accept) begin
                err_q <= 1'b0;
            end else if (wd_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // Vertex outputs are registered one state ahead: the transition into SENDn
    // loads the value that is visible while in SENDn. V0 is driven straight
    // from the inputs at acceptance, so only V1 and V2 need holding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            nt    <= 1'b0;
            xi    <= '0;
            yi    <= '0;
            done  <= 1'b0;
            v1x_q <= '0;
            v1y_q <= '0;
            v2x_q <= '0;
            v2y_q <= '0;
        end else begin
            nt   <= 1'b0;
            xi   <= '0;
            yi   <= '0;
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        v1x_q <= v1x;
                        v1y_q <= v1y;
                        v2x_q <= v2x;
                        v2y_q <= v2y;
                        nt    <= 1'b1;
                        xi    <= v0x;
                        yi    <= v0y;
                        state <= ST_SEND0;
                    end
                end
                ST_SEND0: begin
                    xi    <= v1x_q;
                    yi    <= v1y_q;
                    state <= ST_SEND1;
                end
                ST_SEND1: begin
                    xi    <= v2x_q;
                    yi    <= v2y_q;
                    state <= ST_SEND2;
                end
                ST_SEND2: begin
                    state <= ST_WAITB;
                end
                ST_WAITB: begin
                    if (busy) begin
                        state <= ST_COLLECT;
                    end else if (wd_hit) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_COLLECT: begin
                    if (!busy || wd_hit) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    tri_bitmap u_bitmap (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .we      ((state == ST_COLLECT) && busy && po),
        .idx     (pix_idx(xo, yo)),
        .bitmap  (bitmap),
        .pix_cnt (pix_cnt)
    );

endmodule

// File: tb/tb_tri_host.sv
// Directed bench for tri_host: plays the rasterizer side, checks vertex
// sequencing, bitmap/count accumulation, start filtering, reset and waits.
// Ports: none (top-level bench).
module tb_tri_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  v0x, v0y, v1x, v1y, v2x, v2y;
    logic        nt;
    logic [2:0]  xi, yi;
    logic        busy, po;
    logic [2:0]  xo, yo;
    logic        ready, done;
    logic [63:0] bitmap;
    logic [6:0]  pix_cnt;
    logic        err;

    int n_chk  = 0;
    int n_bad  = 0;
    int done_cnt = 0;

    logic [2:0] px[$];
    logic [2:0] py[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    tri_host dut (
        .clk(clk), .reset(reset), .start(start),
        .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
        .nt(nt), .xi(xi), .yi(yi),
        .busy(busy), .po(po), .xo(xo), .yo(yo),
        .ready(ready), .done(done), .bitmap(bitmap), .pix_cnt(pix_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues start and checks the three vertex beats; returns in the V2 cycle.
    task automatic send_tri(input logic [2:0] ax, input logic [2:0] ay,
                            input logic [2:0] bx, input logic [2:0] by,
                            input logic [2:0] cx, input logic [2:0] cy,
                            input string tag);
        @(negedge clk);
        v0x = ax; v0y = ay; v1x = bx; v1y = by; v2x = cx; v2y = cy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " v0 nt"}, 64'(nt), 64'd1);
        chk({tag, " v0 xy"}, 64'({xi, yi}), 64'({ax, ay}));
        chk({tag, " clear bitmap"}, bitmap, 64'd0);
        chk({tag, " clear cnt"}, 64'(pix_cnt), 64'd0);
        chk({tag, " clear err"}, 64'(err), 64'd0);
        chk({tag, " ready low"}, 64'(ready), 64'd0);
        @(negedge clk);
        chk({tag, " v1 nt"}, 64'(nt), 64'd0);
        chk({tag, " v1 xy"}, 64'({xi, yi}), 64'({bx, by}));
        @(negedge clk);
        chk({tag, " v2 nt"}, 64'(nt), 64'd0);
        chk({tag, " v2 xy"}, 64'({xi, yi}), 64'({cx, cy}));
    endtask

    // Rasterizer response: busy one cycle after V2, then the queued points,
    // then busy low; checks the done timing and final coverage.
    task automatic respond(input bit poke_start, input logic [63:0] exp_bm,
                           input int exp_cnt, input string tag);
        @(negedge clk);
        busy = 1'b1;
        chk({tag, " idle vertex bus"}, 64'({nt, xi, yi}), 64'd0);
        foreach (px[i]) begin
            @(negedge clk);
            po = 1'b1; xo = px[i]; yo = py[i];
            start = (poke_start && i == 1);
        end
        @(negedge clk);
        start = 1'b0;
        po = 1'b0;
        busy = 1'b0;
        chk({tag, " no early done"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({tag, " done pulse"}, 64'(done), 64'd1);
        chk({tag, " pix_cnt"}, 64'(pix_cnt), 64'(exp_cnt));
        chk({tag, " bitmap"}, bitmap, exp_bm);
        @(negedge clk);
        chk({tag, " done single"}, 64'(done), 64'd0);
        chk({tag, " ready after"}, 64'(ready), 64'd1);
        chk({tag, " bitmap held"}, bitmap, exp_bm);
        px.delete();
        py.delete();
    endtask

    initial begin
        int snap;
        reset = 1'b1; start = 1'b0; busy = 1'b0; po = 1'b0; xo = '0; yo = '0;
        v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
        repeat (2) @(negedge clk);
        chk("rst nt", 64'(nt), 64'd0);
        chk("rst xy", 64'({xi, yi}), 64'd0);
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        chk("rst bitmap", bitmap, 64'd0);
        chk("rst cnt", 64'(pix_cnt), 64'd0);
        reset = 1'b0;

        // Reset mid-SEND1: outputs return to reset values at once, no done.
        @(negedge clk);
        v0x = 3'd1; v0y = 3'd0; v1x = 3'd4; v1y = 3'd0; v2x = 3'd2; v2y = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-reset v1 xy", 64'({xi, yi}), 64'({3'd4, 3'd0}));
        snap = done_cnt;
        reset = 1'b1;
        #1;
        chk("midrst nt", 64'(nt), 64'd0);
        chk("midrst xy", 64'({xi, yi}), 64'd0);
        chk("midrst ready", 64'(ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst no done", 64'(done_cnt), 64'(snap));
        chk("midrst still idle", 64'(ready), 64'd1);

        // Job 1: duplicate point (1,1) counted once.
        px = '{3'd1, 3'd2, 3'd1, 3'd7};
        py = '{3'd1, 3'd1, 3'd1, 3'd7};
        send_tri(3'd1, 3'd0, 3'd4, 3'd0, 3'd2, 3'd3, "job1");
        respond(1'b0, 64'h8000_0000_0000_0600, 3, "job1");

        // Job 2: start poked mid-COLLECT is ignored; prior bitmap cleared.
        px = '{3'd3, 3'd3, 3'd3};
        py = '{3'd2, 3'd2, 3'd2};
        send_tri(3'd0, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7, "job2");
        respond(1'b1, 64'h0000_0000_0008_0000, 1, "job2");

        // Job 3: full coverage plus one repeat; the count must reach 64.
        for (int i = 0; i < 64; i++) begin
            px.push_back(3'(i % 8));
            py.push_back(3'(i / 8));
        end
        px.push_back(3'd0);
        py.push_back(3'd0);
        send_tri(3'd7, 3'd7, 3'd0, 3'd7, 3'd7, 3'd0, "job3");
        respond(1'b0, {64{1'b1}}, 64, "job3");

        // busy never rises after V2.
        send_tri(3'd5, 3'd6, 3'd1, 3'd2, 3'd3, 3'd4, "wait");
`ifdef TRI_HOST_TIMEOUT_EN
        repeat (4) begin
            @(negedge clk);
            chk("tmo no early done", 64'(done), 64'd0);
        end
        @(negedge clk);
        chk("tmo done", 64'(done), 64'd1);
        chk("tmo err", 64'(err), 64'd1);
        @(negedge clk);
        chk("tmo done single", 64'(done), 64'd0);
        chk("tmo err sticky", 64'(err), 64'd1);
        chk("tmo ready", 64'(ready), 64'd1);
        send_tri(3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, "after tmo");
        respond(1'b0, 64'd0, 0, "after tmo");
`else
        snap = done_cnt;
        repeat (20) @(negedge clk);
        chk("waitb no done", 64'(done_cnt), 64'(snap));
        chk("waitb not ready", 64'(ready), 64'd0);
        chk("waitb err", 64'(err), 64'd0);
        respond(1'b0, 64'd0, 0, "late busy");
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
